// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU sharing arbiter: opcodes, request id width, tag record.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_LT   = 4'd5,
        ALU_NONE = 4'd6,
        ALU_SHL  = 4'd7,
        ALU_SHR  = 4'd8
    } alu_op_e;

    localparam int REQ_ID_W = 1;

    typedef struct packed {
        logic                valid;
        logic                killed;
        logic [REQ_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin picker; the pointer names the requester favoured on a tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       block,
    output logic [1:0] grant
);

    logic rr_ptr;

    // NOTE: grant gets a default before any branch so no latch is inferred.
    always_comb begin
        grant = 2'b00;
        if (!block) begin
            if (req == 2'b11)
                grant = rr_ptr ? 2'b10 : 2'b01;
            else
                grant = req;
        end
    end

    // Pointer moves to the loser: granting 0 favours 1 next time and vice versa.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rr_ptr <= 1'b0;
        else if (|grant)
            rr_ptr <= grant[0];
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one pipelined ALU between the ID path (id 0) and the branch/address helper (id 1),
// tracking in-flight ops in a tag pipeline so each result returns to its issuer.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int ALU_LATENCY = 1,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_op_a,
    input  logic [DATA_W-1:0] req0_op_b,
    input  logic [DATA_W-1:0] req0_imme,
    input  logic              req0_alusrc,
    input  logic [3:0]        req0_aluop,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_op_a,
    input  logic [DATA_W-1:0] req1_op_b,
    input  logic [DATA_W-1:0] req1_imme,
    input  logic              req1_alusrc,
    input  logic [3:0]        req1_aluop,
    output logic [DATA_W-1:0] alu_read_data_1,
    output logic [DATA_W-1:0] alu_read_data_2,
    output logic [DATA_W-1:0] alu_imme,
    output logic              alu_alusrc,
    output logic [3:0]        alu_aluop,
    output logic              alu_issue,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_done,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_zero,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_zero,
    input  logic              flush,
    output logic              protocol_err
);

    logic [1:0]          grant;
    logic [REQ_ID_W-1:0] grant_id;
    tag_t                tags [ALU_LATENCY];
    tag_t                last;
    logic                done_ok;

    // Reset also blocks grants so every output reads zero while reset is held.
    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({req1_valid, req0_valid}),
        .block (flush | reset),
        .grant (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign alu_issue  = |grant;
    assign grant_id   = grant[1];

    always_comb begin
        alu_read_data_1 = '0;
        alu_read_data_2 = '0;
        alu_imme        = '0;
        alu_alusrc      = 1'b0;
        alu_aluop       = reset ? 4'd0 : ALU_NONE;
        if (grant[0]) begin
            alu_read_data_1 = req0_op_a;
            alu_read_data_2 = req0_op_b;
            alu_imme        = req0_imme;
            alu_alusrc      = req0_alusrc;
            alu_aluop       = req0_aluop;
        end else if (grant[1]) begin
            alu_read_data_1 = req1_op_a;
            alu_read_data_2 = req1_op_b;
            alu_imme        = req1_imme;
            alu_alusrc      = req1_alusrc;
            alu_aluop       = req1_aluop;
        end
    end

    // NOTE: the tag shift register is tiny and must start empty, so every entry is reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ALU_LATENCY; i++)
                tags[i] <= '0;
        end else begin
            tags[0] <= '{valid: alu_issue, killed: flush & alu_issue, id: grant_id};
            for (int i = 1; i < ALU_LATENCY; i++)
                tags[i] <= '{valid:  tags[i-1].valid,
                             killed: tags[i-1].killed | (flush & tags[i-1].valid),
                             id:     tags[i-1].id};
        end
    end

    assign last = tags[ALU_LATENCY-1];

    // A flush in the completion cycle suppresses that completion as well.
    assign done_ok     = last.valid & ~last.killed & alu_done & ~flush;
    assign rsp0_valid  = done_ok & (last.id == 1'b0);
    assign rsp1_valid  = done_ok & (last.id == 1'b1);
    assign rsp0_result = rsp0_valid ? alu_result : '0;
    assign rsp0_zero   = rsp0_valid & alu_zero;
    assign rsp1_result = rsp1_valid ? alu_result : '0;
    assign rsp1_zero   = rsp1_valid & alu_zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            protocol_err <= 1'b0;
        else if (last.valid != alu_done)
            protocol_err <= 1'b1;
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: one instance at ALU latency 1 and one at latency 2, each fed by a small ALU model.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int DW = 32;

    typedef struct packed {
        logic          valid;
        logic [3:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] imm;
        logic          src;
    } req_t;

    typedef struct packed {
        req_t          r0;
        req_t          r1;
        logic [1:0]    eg;
        logic [3:0]    eop;
        logic [DW-1:0] ed1;
        logic [DW-1:0] ed2;
        logic [DW-1:0] eimm;
        logic          esrc;
        logic [DW-1:0] eres;
        logic          ez;
    } vec_t;

    typedef struct {
        logic          id;
        logic [DW-1:0] res;
        logic          zero;
        int            due;
    } sb_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, flush, inject;
    logic          req0_valid, req1_valid, req0_alusrc, req1_alusrc;
    logic [3:0]    req0_aluop, req1_aluop;
    logic [DW-1:0] req0_op_a, req0_op_b, req0_imme, req1_op_a, req1_op_b, req1_imme;

    logic          rdy0_1, rdy1_1, src_1, issue_1, zero_1, done_1, rsp0_v_1, rsp1_v_1, rsp0_z_1, rsp1_z_1, err_1;
    logic [3:0]    op_1;
    logic [DW-1:0] d1_1, d2_1, imm_1, res_1, rsp0_r_1, rsp1_r_1;
    logic          rdy0_2, rdy1_2, src_2, issue_2, zero_2, done_2, rsp0_v_2, rsp1_v_2, rsp0_z_2, rsp1_z_2, err_2;
    logic [3:0]    op_2;
    logic [DW-1:0] d1_2, d2_2, imm_2, res_2, rsp0_r_2, rsp1_r_2;

    alu_share_arbiter #(.ALU_LATENCY(1), .DATA_W(DW)) u_dut1 (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(rdy0_1), .req0_op_a(req0_op_a), .req0_op_b(req0_op_b),
        .req0_imme(req0_imme), .req0_alusrc(req0_alusrc), .req0_aluop(req0_aluop),
        .req1_valid(req1_valid), .req1_ready(rdy1_1), .req1_op_a(req1_op_a), .req1_op_b(req1_op_b),
        .req1_imme(req1_imme), .req1_alusrc(req1_alusrc), .req1_aluop(req1_aluop),
        .alu_read_data_1(d1_1), .alu_read_data_2(d2_1), .alu_imme(imm_1), .alu_alusrc(src_1),
        .alu_aluop(op_1), .alu_issue(issue_1), .alu_result(res_1), .alu_zero(zero_1), .alu_done(done_1),
        .rsp0_valid(rsp0_v_1), .rsp0_result(rsp0_r_1), .rsp0_zero(rsp0_z_1),
        .rsp1_valid(rsp1_v_1), .rsp1_result(rsp1_r_1), .rsp1_zero(rsp1_z_1),
        .flush(flush), .protocol_err(err_1)
    );

    alu_share_arbiter #(.ALU_LATENCY(2), .DATA_W(DW)) u_dut2 (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(rdy0_2), .req0_op_a(req0_op_a), .req0_op_b(req0_op_b),
        .req0_imme(req0_imme), .req0_alusrc(req0_alusrc), .req0_aluop(req0_aluop),
        .req1_valid(req1_valid), .req1_ready(rdy1_2), .req1_op_a(req1_op_a), .req1_op_b(req1_op_b),
        .req1_imme(req1_imme), .req1_alusrc(req1_alusrc), .req1_aluop(req1_aluop),
        .alu_read_data_1(d1_2), .alu_read_data_2(d2_2), .alu_imme(imm_2), .alu_alusrc(src_2),
        .alu_aluop(op_2), .alu_issue(issue_2), .alu_result(res_2), .alu_zero(zero_2), .alu_done(done_2),
        .rsp0_valid(rsp0_v_2), .rsp0_result(rsp0_r_2), .rsp0_zero(rsp0_z_2),
        .rsp1_valid(rsp1_v_2), .rsp1_result(rsp1_r_2), .rsp1_zero(rsp1_z_2),
        .flush(flush), .protocol_err(err_2)
    );

    function automatic logic [DW-1:0] alu_f(input logic [3:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            ALU_LT:  return {{(DW-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SHL: return a << b[4:0];
            ALU_SHR: return a >> b[4:0];
            default: return '0;
        endcase
    endfunction

    // ALU models, reset together with the arbiters; inject forces a stray done on the latency-1 ALU.
    logic          m1_v;
    logic [DW-1:0] m1_r;
    logic [1:0]    m2_v;
    logic [DW-1:0] m2_r [2];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m1_v <= 1'b0;
            m1_r <= '0;
            m2_v <= 2'b00;
            m2_r[0] <= '0;
            m2_r[1] <= '0;
        end else begin
            m1_v    <= issue_1;
            m1_r    <= alu_f(op_1, d1_1, src_1 ? imm_1 : d2_1);
            m2_v    <= {m2_v[0], issue_2};
            m2_r[0] <= alu_f(op_2, d1_2, src_2 ? imm_2 : d2_2);
            m2_r[1] <= m2_r[0];
        end
    end

    assign done_1 = m1_v | inject;
    assign res_1  = m1_r;
    assign zero_1 = (m1_r == '0);
    assign done_2 = m2_v[1];
    assign res_2  = m2_r[1];
    assign zero_2 = (m2_r[1] == '0);

    int  n_checks = 0;
    int  n_pass   = 0;
    int  cyc      = 0;
    sb_t sbq [$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic req_t mk(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                input logic [DW-1:0] imm, input logic src);
        return '{valid: 1'b1, op: op, a: a, b: b, imm: imm, src: src};
    endfunction

    function automatic vec_t mkv(input req_t r0, input req_t r1, input logic [1:0] eg,
                                 input logic [3:0] eop, input logic [DW-1:0] ed1, input logic [DW-1:0] ed2,
                                 input logic [DW-1:0] eimm, input logic esrc,
                                 input logic [DW-1:0] eres, input logic ez);
        return '{r0: r0, r1: r1, eg: eg, eop: eop, ed1: ed1, ed2: ed2, eimm: eimm, esrc: esrc,
                 eres: eres, ez: ez};
    endfunction

    task automatic drive(input req_t r0, input req_t r1);
        req0_valid = r0.valid; req0_aluop = r0.op; req0_op_a = r0.a; req0_op_b = r0.b;
        req0_imme  = r0.imm;   req0_alusrc = r0.src;
        req1_valid = r1.valid; req1_aluop = r1.op; req1_op_a = r1.a; req1_op_b = r1.b;
        req1_imme  = r1.imm;   req1_alusrc = r1.src;
    endtask

    task automatic cycle(input req_t r0, input req_t r1, input logic fl);
        @(negedge clk);
        drive(r0, r1);
        flush = fl;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive('0, '0);
        flush  = 1'b0;
        inject = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Scoreboard for the latency-1 instance: pop when a response is due, otherwise expect silence.
    task automatic sb_step(input vec_t v, input int idx);
        sb_t e;
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            check($sformatf("v%0d_rsp0_valid", idx), rsp0_v_1, e.id == 1'b0);
            check($sformatf("v%0d_rsp1_valid", idx), rsp1_v_1, e.id == 1'b1);
            check($sformatf("v%0d_rsp_result", idx), e.id ? rsp1_r_1 : rsp0_r_1, e.res);
            check($sformatf("v%0d_rsp_zero", idx), e.id ? rsp1_z_1 : rsp0_z_1, e.zero);
        end else begin
            check($sformatf("v%0d_no_rsp", idx), {rsp1_v_1, rsp0_v_1}, 2'b00);
        end
        if (v.eg != 2'b00)
            sbq.push_back('{id: v.eg[1], res: v.eres, zero: v.ez, due: cyc + 1});
        cyc++;
    endtask

    localparam req_t IDLE = '0;
    vec_t vecs [13];

    initial begin
        vecs[0]  = mkv(mk(ALU_ADD, 5, 7, 0, 0), IDLE, 2'b01, ALU_ADD, 5, 7, 0, 0, 12, 0);
        vecs[1]  = mkv(IDLE, IDLE, 2'b00, ALU_NONE, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mkv(IDLE, mk(ALU_XOR, 'hA, 'h5, 0, 0), 2'b10, ALU_XOR, 'hA, 'h5, 0, 0, 'hF, 0);
        vecs[3]  = mkv(mk(ALU_SUB, 9, 9, 0, 0), mk(ALU_OR, 'hF0, 'h0F, 0, 0), 2'b01, ALU_SUB, 9, 9, 0, 0, 0, 1);
        vecs[4]  = mkv(mk(ALU_SUB, 9, 9, 0, 0), mk(ALU_OR, 'hF0, 'h0F, 0, 0), 2'b10, ALU_OR, 'hF0, 'h0F, 0, 0, 'hFF, 0);
        vecs[5]  = mkv(mk(ALU_AND, 'hFF00, 'h0FF0, 0, 0), mk(ALU_LT, 3, 5, 0, 0), 2'b01, ALU_AND, 'hFF00, 'h0FF0, 0, 0, 'h0F00, 0);
        vecs[6]  = mkv(mk(ALU_AND, 'hFF00, 'h0FF0, 0, 0), mk(ALU_LT, 3, 5, 0, 0), 2'b10, ALU_LT, 3, 5, 0, 0, 1, 0);
        vecs[7]  = mkv(IDLE, mk(ALU_SHL, 1, 100, 3, 1), 2'b10, ALU_SHL, 1, 100, 3, 1, 8, 0);
        vecs[8]  = mkv(mk(ALU_SHR, 'h80, 4, 0, 0), mk(ALU_ADD, 10, 999, 20, 1), 2'b01, ALU_SHR, 'h80, 4, 0, 0, 8, 0);
        vecs[9]  = mkv(mk(ALU_SHR, 'h80, 4, 0, 0), mk(ALU_ADD, 10, 999, 20, 1), 2'b10, ALU_ADD, 10, 999, 20, 1, 30, 0);
        vecs[10] = mkv(mk(ALU_ADD, 'hFFFF_FFFF, 1, 0, 0), IDLE, 2'b01, ALU_ADD, 'hFFFF_FFFF, 1, 0, 0, 0, 1);
        vecs[11] = mkv(IDLE, IDLE, 2'b00, ALU_NONE, 0, 0, 0, 0, 0, 0);
        vecs[12] = mkv(IDLE, IDLE, 2'b00, ALU_NONE, 0, 0, 0, 0, 0, 0);

        // Reset state, with both requesters pushing so blocked grants are visible.
        reset = 1'b1; flush = 1'b0; inject = 1'b0;
        drive(mk(ALU_ADD, 1, 1, 0, 0), mk(ALU_SUB, 2, 2, 0, 0));
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", {rdy1_1, rdy0_1, rdy1_2, rdy0_2}, 4'b0000);
        check("rst_issue", {issue_1, issue_2}, 2'b00);
        check("rst_aluop", op_1, 4'd0);
        check("rst_operands", d1_1 | d2_1 | imm_1, 0);
        check("rst_rsp", {rsp0_v_1, rsp1_v_1, rsp0_v_2, rsp1_v_2}, 4'b0000);
        check("rst_err", {err_1, err_2}, 2'b00);
        drive(IDLE, IDLE);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            cycle(vecs[i].r0, vecs[i].r1, 1'b0);
            check($sformatf("v%0d_ready0", i), rdy0_1, vecs[i].eg[0]);
            check($sformatf("v%0d_ready1", i), rdy1_1, vecs[i].eg[1]);
            check($sformatf("v%0d_issue", i), issue_1, |vecs[i].eg);
            check($sformatf("v%0d_aluop", i), op_1, vecs[i].eop);
            check($sformatf("v%0d_rd1", i), d1_1, vecs[i].ed1);
            check($sformatf("v%0d_rd2", i), d2_1, vecs[i].ed2);
            check($sformatf("v%0d_imme", i), imm_1, vecs[i].eimm);
            check($sformatf("v%0d_alusrc", i), src_1, vecs[i].esrc);
            sb_step(vecs[i], i);
        end
        check("sb_drained", sbq.size(), 0);
        check("table_no_err", err_1, 1'b0);

        // Latency 1: flush lands in the completion cycle, so the response is dropped quietly.
        cycle(mk(ALU_ADD, 1, 1, 0, 0), IDLE, 1'b0);
        check("fc_issue", rdy0_1, 1'b1);
        cycle(IDLE, IDLE, 1'b1);
        check("fc_suppressed", rsp0_v_1, 1'b0);
        cycle(IDLE, IDLE, 1'b0);
        check("fc_no_rsp", rsp0_v_1, 1'b0);
        check("fc_no_err", err_1, 1'b0);

        // Latency 2: issue at T, flush at T+1, fresh request at T+2 completes at T+4.
        do_reset();
        cycle(mk(ALU_ADD, 2, 3, 0, 0), IDLE, 1'b0);
        check("fl_T_ready0", rdy0_2, 1'b1);
        cycle(mk(ALU_ADD, 6, 6, 0, 0), IDLE, 1'b1);
        check("fl_T1_no_grant", {rdy1_2, rdy0_2, issue_2}, 3'b000);
        cycle(mk(ALU_ADD, 4, 4, 0, 0), IDLE, 1'b0);
        check("fl_T2_killed", rsp0_v_2, 1'b0);
        check("fl_T2_ready0", rdy0_2, 1'b1);
        check("fl_T2_err", err_2, 1'b0);
        cycle(IDLE, IDLE, 1'b0);
        check("fl_T3_quiet", rsp0_v_2, 1'b0);
        cycle(IDLE, IDLE, 1'b0);
        check("fl_T4_rsp0", rsp0_v_2, 1'b1);
        check("fl_T4_result", rsp0_r_2, 8);
        check("fl_T4_rsp1", rsp1_v_2, 1'b0);
        cycle(IDLE, IDLE, 1'b0);
        check("fl_T5_err", err_2, 1'b0);

        // Stray done with an empty pipeline: sticky until reset.
        do_reset();
        cycle(IDLE, IDLE, 1'b0);
        inject = 1'b1;
        #1;
        check("pe_before_edge", err_1, 1'b0);
        check("pe_no_rsp", {rsp1_v_1, rsp0_v_1}, 2'b00);
        cycle(IDLE, IDLE, 1'b0);
        inject = 1'b0;
        check("pe_set", err_1, 1'b1);
        repeat (10) cycle(IDLE, IDLE, 1'b0);
        check("pe_sticky", err_1, 1'b1);
        check("pe_other_clean", err_2, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("pe_cleared", err_1, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Reset with two ops in flight on the latency-2 instance and rr_ptr pointing at req1.
        cycle(mk(ALU_ADD, 1, 2, 0, 0), mk(ALU_SUB, 5, 3, 0, 0), 1'b0);
        check("mr_first_grant0", rdy0_2, 1'b1);
        cycle(mk(ALU_ADD, 3, 4, 0, 0), IDLE, 1'b0);
        check("mr_second_grant0", rdy0_2, 1'b1);
        @(negedge clk);
        drive(mk(ALU_ADD, 1, 1, 0, 0), mk(ALU_SUB, 1, 1, 0, 0));
        reset = 1'b1;
        #1;
        check("mr_ready_zero", {rdy1_1, rdy0_1, rdy1_2, rdy0_2}, 4'b0000);
        check("mr_issue_zero", {issue_1, issue_2}, 2'b00);
        check("mr_aluop_zero", op_2, 4'd0);
        check("mr_rsp_zero", {rsp0_v_2, rsp1_v_2, rsp0_v_1, rsp1_v_1}, 4'b0000);
        check("mr_err_zero", {err_1, err_2}, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mr_ptr_reset_2", {rdy1_2, rdy0_2}, 2'b01);
        check("mr_ptr_reset_1", {rdy1_1, rdy0_1}, 2'b01);
        repeat (4) cycle(IDLE, IDLE, 1'b0);
        check("mr_no_err", {err_1, err_2}, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single registered EX/ALU unit between two requesters: requester 0 is the main ID path, requester 1 is the branch/address helper.
- Each cycle it arbitrates, drives the ALU operand/control inputs plus a one-cycle issue strobe, and tracks in-flight ops in a tag pipeline.
- Returns each result to the requester that issued it. Also supports flush and detects protocol errors.

Parameters:
- ALU_LATENCY, 1, cycles from the issue strobe to the ALU's result-valid strobe (1..4).
- DATA_W, 32, operand/result width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle (grant)
- reqN_op_a  in  DATA_W  operand 1
- reqN_op_b  in  DATA_W  register operand 2
- reqN_imme  in  DATA_W  immediate
- reqN_alusrc  in  1  1 = use immediate as operand 2
- reqN_aluop  in  4  ALU opcode
- alu_read_data_1 / alu_read_data_2 / alu_imme  out  DATA_W  muxed operands to ALU
- alu_alusrc  out  1  muxed control
- alu_aluop  out  4  muxed control
- alu_issue  out  1  one-cycle issue strobe (ALU kick-up input)
- alu_result  in  DATA_W  ALU result
- alu_zero  in  1  ALU zero flag
- alu_done  in  1  ALU result-valid strobe (ALU kick-up output)
- rsp0_valid / rsp1_valid  out  1  one-cycle response strobe
- rspN_result  out  DATA_W  result
- rspN_zero  out  1  zero flag
- flush  in  1  kill all in-flight ops
- protocol_err  out  1  sticky error flag

Behaviour:
- Reset values: all outputs 0; rr_ptr = 0 (requester 0 favoured); tag pipeline empty.
- Arbitration (combinational from the registered rr_ptr):
  - If only one requester is valid, it is granted.
  - If both are valid, the requester at rr_ptr is granted.
  - On any grant, rr_ptr moves to the non-granted requester. Without a grant, rr_ptr holds.
- No grant when flush = 1.
- reqN_ready = grant to N. Requester inputs are sampled in the same cycle. No ready-before-valid dependency: ready is never asserted without valid.
- Issue path:
  - alu_issue = (any grant).
  - Operand/control outputs are muxed combinationally from the granted requester.
  - With no grant, the operand/control outputs drive zeros and aluop = 4'd6 (NONE).
- Back-to-back issue is allowed every cycle; the ALU is fully pipelined from this block's view.
- Tag pipeline: shift register of depth ALU_LATENCY; each entry holds {valid, killed, id}.
  - Stage 0 loads {alu_issue, 0, granted id} each cycle.
  - Entries advance one stage per cycle.
- Completion: the last stage is compared against alu_done each cycle.
  - valid & !killed & alu_done: rspN_valid = 1 for id N, for exactly 1 cycle. rspN_result / rspN_zero come from the ALU. No backpressure; the requester must consume.
  - valid & killed & alu_done: dropped, no response, no error.
  - valid & !alu_done, or !valid & alu_done: protocol_err set. It stays set until reset.
- rsp outputs are combinational from the tag pipeline and ALU signals (zero added latency). rspN_result / rspN_zero are held at 0 when rspN_valid = 0.
- Flush:
  - Sets killed on every valid entry, including any loaded that cycle (none, because grants are blocked).
  - Flush spanning multiple cycles keeps blocking grants.
  - Ops issued after flush deasserts complete normally.
- Simultaneous flush and completion of the last stage in the same cycle: that completion is suppressed.
- Reset mid-operation clears all tags. ALU results arriving after reset release therefore raise protocol_err; the system resets the ALU concurrently.
- Widths: no arithmetic here apart from ptr toggle. The id is 1 bit.

Decomposition:
- Shared package alu_pkg:
  - ALU opcode constants ADD=0, SUB=1, AND=2, OR=3, XOR=4, LT=5, NONE=6, SHL=7, SHR=8.
  - REQ_ID_W = 1.
  - Tag struct {valid, killed, id}.
- One sub-module: rr_arb2. It is the 2-way round-robin picker holding rr_ptr, with outputs grant[1:0].
- Tag pipeline and muxing stay in the top level.

Test Plan:
- After reset, req0 only: ADD a=5 b=7 for 1 cycle. Expect req0_ready=1, alu_issue=1, aluop=0 the same cycle; next cycle rsp0_valid=1, result=12, zero=0; rsp1_valid stays 0.
- Both valid for 4 consecutive cycles. Expect grants 0,1,0,1. Responses alternate rsp0/rsp1 one cycle later. Results: SUB 9-9 gives 0 with zero=1; OR 0xF0|0x0F gives 0xFF.
- req1 with alusrc=1, imme=3, op_b=100, SHL a=1. Expect alu_read_data_2=100, alu_imme=3, alu_alusrc=1; rsp1_result=8.
- Issue req0 at T, assert flush at T+1 (ALU_LATENCY=2). Expect no grant at T+1; no rsp0 at T+2; protocol_err=0; a request at T+2 completes normally at T+4.
- Inject alu_done=1 with an empty pipeline. Expect protocol_err=1, still 1 after 10 idle cycles; cleared only by reset=1.
- Assert reset=1 mid-stream with 2 ops in flight. Expect all outputs 0 immediately (asynchronous); rr_ptr back to 0, so both-valid afterwards grants req0 first.
